// File: rtl/pwm_duty_scheduler.sv
// Duty-cycle scheduler for a PWM generator: accepts target duties, slews the applied
// duty by at most STEP per PWM period, and sequences run/stop/fault behaviour.
module pwm_duty_scheduler #(
    parameter int N    = 10,
    parameter int STEP = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         run_req,
    input  logic         fault,
    input  logic         period_start,
    input  logic         req_valid,
    input  logic [N-1:0] req_duty,
    output logic         req_ready,
    output logic [N-1:0] duty_out,
    output logic         pwm_enable,
    output logic         at_target,
    output logic [2:0]   state
);

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        RAMP  = 3'b001,
        RUN   = 3'b010,
        STOP  = 3'b011,
        FAULT = 3'b100
    } state_t;

    localparam logic [N:0] STEP_W = (N+1)'(STEP);

    // One slew step in N+1 bits; the result is clamped to goal, so it can never wrap.
    function automatic logic [N-1:0] slew_toward(input logic [N-1:0] cur, input logic [N-1:0] goal);
        logic [N:0] cur_w;
        logic [N:0] goal_w;
        logic [N:0] res_w;
        cur_w  = {1'b0, cur};
        goal_w = {1'b0, goal};
        if (goal_w >= cur_w) begin
            if ((goal_w - cur_w) <= STEP_W) res_w = goal_w;
            else                            res_w = cur_w + STEP_W;
        end else begin
            if ((cur_w - goal_w) <= STEP_W) res_w = goal_w;
            else                            res_w = cur_w - STEP_W;
        end
        return res_w[N-1:0];
    endfunction

    state_t       state_r;
    state_t       state_s;
    logic [N-1:0] duty_r;
    logic [N-1:0] duty_s;
    logic [N-1:0] target_r;
    logic         en_r;
    logic         en_s;
    logic         accept_s;
    logic [N-1:0] ramp_next_s;
    logic [N-1:0] stop_next_s;

    // A live fault also closes the handshake, so a request never races fault entry.
    assign req_ready   = (state_r != FAULT) && !fault;
    assign accept_s    = req_valid && req_ready;
    assign ramp_next_s = slew_toward(duty_r, target_r);
    assign stop_next_s = slew_toward(duty_r, {N{1'b0}});

    assign duty_out   = duty_r;
    assign pwm_enable = en_r;
    assign state      = state_r;
    assign at_target  = (duty_r == target_r);

    // Target register: loads on every accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_r <= {N{1'b0}};
        end else if (accept_s) begin
            target_r <= req_duty;
        end else begin
            target_r <= target_r;
        end
    end

    // State, applied duty and enable registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            duty_r  <= {N{1'b0}};
            en_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            duty_r  <= duty_s;
            en_r    <= en_s;
        end
    end

    // Next-state, next-duty and next-enable decode; fault overrides everything.
    always_comb begin
        state_s = state_r;
        duty_s  = duty_r;
        en_s    = en_r;
        if (fault) begin
            state_s = FAULT;
            duty_s  = {N{1'b0}};
            en_s    = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    duty_s = {N{1'b0}};
                    if (run_req) begin
                        state_s = RAMP;
                        en_s    = 1'b1;
                    end else begin
                        state_s = IDLE;
                        en_s    = 1'b0;
                    end
                end
                RAMP: begin
                    if (!run_req) begin
                        state_s = STOP;
                    end else if (period_start) begin
                        duty_s = ramp_next_s;
                        // A differing target accepted on this same edge keeps the ramp going.
                        if ((ramp_next_s == target_r) && !(accept_s && (req_duty != ramp_next_s)))
                            state_s = RUN;
                        else
                            state_s = RAMP;
                    end else begin
                        state_s = RAMP;
                    end
                end
                RUN: begin
                    if (!run_req)                               state_s = STOP;
                    else if (accept_s && (req_duty != duty_r))  state_s = RAMP;
                    else                                        state_s = RUN;
                end
                STOP: begin
                    if (run_req) begin
                        state_s = RAMP;
                    end else if (period_start) begin
                        duty_s = stop_next_s;
                        if (stop_next_s == {N{1'b0}}) begin
                            state_s = IDLE;
                            en_s    = 1'b0;
                        end else begin
                            state_s = STOP;
                        end
                    end else begin
                        state_s = STOP;
                    end
                end
                FAULT: begin
                    duty_s = {N{1'b0}};
                    en_s   = 1'b0;
                    if (!run_req) state_s = IDLE;
                    else          state_s = FAULT;
                end
                default: begin
                    state_s = FAULT;
                    duty_s  = {N{1'b0}};
                    en_s    = 1'b0;
                end
            endcase
        end
    end

endmodule
